alu_cmd_sequencer: RTL and testbench

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

---
 rtl/alu_cmd_sequencer.sv | 98 +++++++++
 tb/tb_alu_cmd_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: sequences one command at a time through an external
// combinational ALU with valid/ready command and response handshakes.
module alu_cmd_sequencer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    input  logic [2:0]       cmd_sel,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [2:0]       alu_sel,
    input  logic [3:0]       alu_result,
    input  logic             alu_carry_out,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [3:0]       rsp_result,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        EXEC = 3'b010,
        RESP = 3'b100
    } state_t;

    state_t state;

    logic sel_bad;
    assign sel_bad = (alu_sel > 3'd4);

    // Command/response FSM; all handshake outputs are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            op_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        alu_a     <= cmd_a;
                        alu_b     <= cmd_b;
                        alu_sel   <= cmd_sel;
                        cmd_ready <= 1'b0;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    if (sel_bad) begin
                        rsp_result <= '0;
                        rsp_carry  <= 1'b0;
                        rsp_zero   <= 1'b0;
                        rsp_err    <= 1'b1;
                    end else begin
                        rsp_result <= alu_result;
                        rsp_carry  <= alu_carry_out;
                        rsp_zero   <= alu_zero;
                        rsp_err    <= 1'b0;
                    end
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        if (!rsp_err) begin
                            op_count <= op_count + CNT_W'(1);
                        end
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed and random commands against a
// behavioural response model, with a small ALU model in the loop.
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [2:0] cmd_sel;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_sel;
    logic [3:0] alu_result;
    logic       alu_carry_out;
    logic       alu_zero;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_result;
    logic       rsp_carry;
    logic       rsp_zero;
    logic       rsp_err;
    logic [1:0] op_count;

    int n_cmp = 0;
    int n_err = 0;
    int exp_count = 0;

    alu_cmd_sequencer #(.CNT_W(2)) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_a(cmd_a),
        .cmd_b(cmd_b),
        .cmd_sel(cmd_sel),
        .alu_a(alu_a),
        .alu_b(alu_b),
        .alu_sel(alu_sel),
        .alu_result(alu_result),
        .alu_carry_out(alu_carry_out),
        .alu_zero(alu_zero),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_result(rsp_result),
        .rsp_carry(rsp_carry),
        .rsp_zero(rsp_zero),
        .rsp_err(rsp_err),
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    // External ALU; invalid opcodes yield junk the sequencer must ignore.
    always_comb begin
        logic [4:0] s;
        s = 5'd0;
        case (alu_sel)
            3'd0: s = {1'b0, alu_a} + {1'b0, alu_b};
            3'd1: s = {1'b0, alu_a} - {1'b0, alu_b};
            3'd2: s = {1'b0, alu_a & alu_b};
            3'd3: s = {1'b0, alu_a | alu_b};
            3'd4: s = {1'b0, ~alu_a};
            default: s = 5'b11010;
        endcase
        alu_result    = s[3:0];
        alu_carry_out = s[4];
        alu_zero      = (alu_sel > 3'd4) ? 1'b1 : (s[3:0] == 4'd0);
    end

    // Expected response {err, carry, zero, result[3:0]} from plain arithmetic.
    function automatic logic [6:0] ref_rsp(int a, int b, int sel);
        int r;
        logic c;
        r = 0;
        c = 1'b0;
        case (sel)
            0: begin r = a + b; c = (r > 15); r = r % 16; end
            1: begin c = (a < b); r = (a - b + 16) % 16; end
            2: r = a & b;
            3: r = a | b;
            4: r = 15 - a;
            default: return 7'b1000000;
        endcase
        return {1'b0, c, (r == 0), 4'(r)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rsp(input string tag, input logic [6:0] e);
        chk({tag, "_res"}, 32'(rsp_result), 32'(e[3:0]));
        chk({tag, "_zero"}, 32'(rsp_zero), 32'(e[4]));
        chk({tag, "_carry"}, 32'(rsp_carry), 32'(e[5]));
        chk({tag, "_err"}, 32'(rsp_err), 32'(e[6]));
    endtask

    task automatic chk_alu(input string tag, input logic [3:0] a,
                           input logic [3:0] b, input logic [2:0] sel);
        chk({tag, "_alu_a"}, 32'(alu_a), 32'(a));
        chk({tag, "_alu_b"}, 32'(alu_b), 32'(b));
        chk({tag, "_alu_sel"}, 32'(alu_sel), 32'(sel));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        chk_rsp(tag, 7'd0);
        chk_alu(tag, 4'd0, 4'd0, 3'd0);
        chk({tag, "_count"}, 32'(op_count), 32'd0);
    endtask

    task automatic rand_cmd();
        cmd_a   = 4'($urandom);
        cmd_b   = 4'($urandom);
        cmd_sel = 3'($urandom);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (!cmd_ready && k < 8) begin
            step();
            k++;
        end
        if (!cmd_ready) chk("idle_timeout", 32'(cmd_ready), 32'd1);
    endtask

    // One full command; stall = cycles rsp_ready is held low in RESP.
    task automatic do_op(input string tag, input logic [3:0] a,
                         input logic [3:0] b, input logic [2:0] sel,
                         input int stall);
        logic [6:0] e;
        e = ref_rsp(int'(a), int'(b), int'(sel));
        wait_idle();
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_sel   = sel;
        rsp_ready = (stall == 0);
        step();
        chk_alu({tag, "_acc"}, a, b, sel);
        chk({tag, "_exec_rv"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_exec_cr"}, 32'(cmd_ready), 32'd0);
        rand_cmd();
        step();
        chk({tag, "_rv"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_cr"}, 32'(cmd_ready), 32'd0);
        chk_rsp(tag, e);
        for (int i = 0; i < stall; i++) begin
            rand_cmd();
            step();
            chk({tag, "_stall_rv"}, 32'(rsp_valid), 32'd1);
            chk({tag, "_stall_cr"}, 32'(cmd_ready), 32'd0);
            chk_rsp({tag, "_stall"}, e);
            chk_alu({tag, "_stall"}, a, b, sel);
        end
        rsp_ready = 1'b1;
        rand_cmd();
        step();
        if (!e[6]) exp_count = (exp_count + 1) % 4;
        chk({tag, "_hs_rv"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_hs_cr"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_count"}, 32'(op_count), 32'(exp_count));
        chk_rsp({tag, "_held"}, e);
        chk_alu({tag, "_noacc"}, a, b, sel);
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
    endtask

    // Reset during EXEC (in_resp=0) or RESP (in_resp=1).
    task automatic abort(input string tag, input bit in_resp);
        wait_idle();
        cmd_valid = 1'b1;
        cmd_a     = 4'd9;
        cmd_b     = 4'd2;
        cmd_sel   = 3'd0;
        rsp_ready = 1'b0;
        step();
        cmd_valid = 1'b0;
        if (in_resp) begin
            step();
            chk({tag, "_pre_rv"}, 32'(rsp_valid), 32'd1);
        end
        rst       = 1'b1;
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        step();
        rst       = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        exp_count = 0;
        chk_reset(tag);
        step();
        chk({tag, "_post_rv"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_post_count"}, 32'(op_count), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        cmd_a     = 4'd0;
        cmd_b     = 4'd0;
        cmd_sel   = 3'd0;
        step();
        step();
        chk_reset("por");
        rst = 1'b0;
        step();
        chk("idle_hold_cr", 32'(cmd_ready), 32'd1);

        do_op("add", 4'b0101, 4'b0011, 3'd0, 0);
        chk("add_lit", 32'(rsp_result), 32'h8);
        chk("cnt1", 32'(op_count), 32'd1);
        do_op("sub", 4'b0101, 4'b0001, 3'd1, 0);
        chk("sub_lit", 32'(rsp_result), 32'h4);
        chk("cnt2", 32'(op_count), 32'd2);
        do_op("and", 4'b1100, 4'b0011, 3'd2, 0);
        chk("and_zero", 32'(rsp_zero), 32'd1);
        chk("cnt3", 32'(op_count), 32'd3);
        do_op("or", 4'b1100, 4'b1010, 3'd3, 5);
        chk("or_lit", 32'(rsp_result), 32'he);
        chk("cnt_wrap", 32'(op_count), 32'd0);
        do_op("bad", 4'b1111, 4'b1111, 3'b111, 1);
        chk("bad_err", 32'(rsp_err), 32'd1);
        chk("bad_cnt", 32'(op_count), 32'd0);
        do_op("not", 4'b0110, 4'b0000, 3'd4, 0);

        abort("rst_exec", 1'b0);
        abort("rst_resp", 1'b1);

        for (int i = 0; i < 24; i++) begin
            do_op("rnd", 4'($urandom), 4'($urandom), 3'($urandom),
                  int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
